// File: rtl/countdown_ctrl.sv
// countdown_ctrl: sequences one countdown run of the down counter downstream.
// IDLE -> LOAD -> RUN <-> PAUSED -> DONE, with abort back to IDLE from anywhere.
// The counter's decrement is prescaled by PRESCALE; completion raises a single
// done cycle and bumps a saturating run counter.
module countdown_ctrl #(
    parameter int dw          = 8,
    parameter int WIDTH       = 7,
    parameter int PRESCALE    = 4,
    parameter int AUTO_RELOAD = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          pause,
    input  logic          abort,
    input  logic [dw-1:0] count,
    output logic          cnt_reset,
    output logic          cnt_ena,
    output logic          busy,
    output logic          paused,
    output logic          done,
    output logic [7:0]    rounds
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    // Elaboration-time guards on the parameter set.
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("countdown_ctrl: PRESCALE must be 1 or more");
    end
    if (WIDTH < 0 || WIDTH >= (1 << dw)) begin : g_bad_width
        $error("countdown_ctrl: WIDTH must fit in dw bits");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RUN    = 3'd2,
        S_PAUSED = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t        state;
    logic [PW-1:0] pre;
    logic          zero;

    assign zero = (count == '0);

    // Sequencer: abort outranks zero-detect, which outranks pause and start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            pre    <= '0;
            rounds <= '0;
        end else if (abort) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) state <= S_LOAD;
                end
                S_LOAD: begin
                    pre   <= '0;
                    state <= S_RUN;
                end
                S_RUN: begin
                    pre <= (pre == PRE_LAST) ? '0 : pre + 1'b1;
                    if (zero)       state <= S_DONE;
                    else if (pause) state <= S_PAUSED;
                end
                S_PAUSED: begin
                    // pre holds so the prescaler resumes where it stopped
                    if (!pause) state <= S_RUN;
                end
                S_DONE: begin
                    // counted on leaving DONE so an abort here leaves rounds alone
                    if (rounds != 8'hFF) rounds <= rounds + 8'd1;
                    state <= (AUTO_RELOAD != 0) ? S_LOAD : S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Moore decodes of state; cnt_ena also gates on the prescaler and zero so
    // the counter is never stepped below zero.
    always_comb begin
        cnt_reset = (state == S_IDLE) || (state == S_LOAD);
        busy      = (state == S_LOAD) || (state == S_RUN) || (state == S_PAUSED);
        paused    = (state == S_PAUSED);
        done      = (state == S_DONE);
        cnt_ena   = (state == S_RUN) && (pre == PRE_LAST) && !zero;
    end

endmodule

// File: tb/tb_countdown_ctrl.sv
// Bench for countdown_ctrl: two instances (default and auto-reload/fast), each
// driving a small down counter, checked every cycle against a timing model plus
// directed literal expectations.
module tb_countdown_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       start0 = 1'b0, pause0 = 1'b0, abort0 = 1'b0;
    logic [7:0] count0;
    logic       cnt_reset0, cnt_ena0, busy0, paused0, done0;
    logic [7:0] rounds0;

    logic       start1 = 1'b0, pause1 = 1'b0, abort1 = 1'b0;
    logic [7:0] count1;
    logic       cnt_reset1, cnt_ena1, busy1, paused1, done1;
    logic [7:0] rounds1;

    countdown_ctrl #(.dw(8), .WIDTH(7), .PRESCALE(4), .AUTO_RELOAD(0)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .pause(pause0), .abort(abort0),
        .count(count0), .cnt_reset(cnt_reset0), .cnt_ena(cnt_ena0), .busy(busy0),
        .paused(paused0), .done(done0), .rounds(rounds0));

    countdown_ctrl #(.dw(8), .WIDTH(2), .PRESCALE(1), .AUTO_RELOAD(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .pause(pause1), .abort(abort1),
        .count(count1), .cnt_reset(cnt_reset1), .cnt_ena(cnt_ena1), .busy(busy1),
        .paused(paused1), .done(done1), .rounds(rounds1));

    // The downstream down counters: reset loads WIDTH, ena steps down by one.
    always @(posedge clk) begin
        if (cnt_reset0)    count0 <= 8'd7;
        else if (cnt_ena0) count0 <= count0 - 8'd1;
        if (cnt_reset1)    count1 <= 8'd2;
        else if (cnt_ena1) count1 <= count1 - 8'd1;
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Timing model: phase of the run, number of RUN cycles elapsed (el), and
    // completed runs. Counter value and prescaler position follow from el.
    localparam int IDLE = 0, LOAD = 1, RUN = 2, PAU = 3, DON = 4;
    int P  [2] = '{4, 1};
    int W  [2] = '{7, 2};
    int AR [2] = '{0, 1};
    int ph [2] = '{-1, -1};
    int el [2] = '{0, 0};
    int rnd[2] = '{0, 0};
    bit prevrst[2] = '{1'b0, 1'b0};

    function automatic int mcnt(input int i);
        int v;
        v = W[i] - el[i] / P[i];
        return (v < 0) ? 0 : v;
    endfunction

    task automatic step(input int i, input logic st, input logic pa, input logic ab);
        prevrst[i] = (ph[i] == IDLE) || (ph[i] == LOAD);
        if (reset) begin
            ph[i] = IDLE; el[i] = 0; rnd[i] = 0;
        end else if (ab) begin
            ph[i] = IDLE;
        end else begin
            case (ph[i])
                IDLE: if (st) ph[i] = LOAD;
                LOAD: begin el[i] = 0; ph[i] = RUN; end
                RUN: begin
                    if (mcnt(i) == 0) ph[i] = DON;
                    else begin
                        el[i]++;
                        if (pa) ph[i] = PAU;
                    end
                end
                PAU: if (!pa) ph[i] = RUN;
                DON: begin
                    if (rnd[i] < 255) rnd[i]++;
                    ph[i] = (AR[i] != 0) ? LOAD : IDLE;
                end
                default: ph[i] = IDLE;
            endcase
        end
    endtask

    task automatic cmp(input int i, input logic cr, input logic ce, input logic bz,
                       input logic pz, input logic dn, input logic [7:0] rd,
                       input logic [7:0] cn);
        string s;
        s = $sformatf("u%0d.", i);
        chk({s, "cnt_reset"}, cr, (ph[i] == IDLE) || (ph[i] == LOAD));
        chk({s, "cnt_ena"}, ce, (ph[i] == RUN) && (el[i] % P[i] == P[i] - 1) && (mcnt(i) != 0));
        chk({s, "busy"}, bz, (ph[i] == LOAD) || (ph[i] == RUN) || (ph[i] == PAU));
        chk({s, "paused"}, pz, ph[i] == PAU);
        chk({s, "done"}, dn, ph[i] == DON);
        chk({s, "rounds"}, rd, rnd[i]);
        if (ph[i] == RUN || ph[i] == PAU) chk({s, "count"}, cn, mcnt(i));
        else if (ph[i] == DON)            chk({s, "count"}, cn, 0);
        else if (prevrst[i])              chk({s, "count"}, cn, W[i]);
    endtask

    // Per-cycle compare: advance model on the edge, check outputs just after.
    initial forever begin
        @(posedge clk);
        cyc++;
        step(0, start0, pause0, abort0);
        step(1, start1, pause1, abort1);
        #1;
        cmp(0, cnt_reset0, cnt_ena0, busy0, paused0, done0, rounds0, count0);
        cmp(1, cnt_reset1, cnt_ena1, busy1, paused1, done1, rounds1, count1);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int tl, t, n, last, ca, t1, t2;

    initial begin
        // reset, then idle
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("idle.cnt_reset", cnt_reset0, 1);
            chk("idle.cnt_ena", cnt_ena0, 0);
            chk("idle.done", done0, 0);
            chk("idle.busy", busy0, 0);
            chk("idle.rounds", rounds0, 0);
        end

        // launch the auto-reloading instance; it keeps running in background
        start1 = 1'b1; tick(); start1 = 1'b0;

        // plain run: 7 enables 4 apart, done 30 after LOAD
        start0 = 1'b1; tick(); start0 = 1'b0;
        tl = cyc; n = 0; t = -1; last = -1;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (cnt_ena0) begin n++; last = cyc; end
            if (done0) begin t = cyc; break; end
        end
        chk("run.latency", t - tl, 30);
        chk("run.ena_pulses", n, 7);
        chk("run.last_ena", last - tl, 28);
        chk("run.count_at_done", count0, 0);
        tick();
        chk("run.rounds", rounds0, 1);
        chk("run.busy_after", busy0, 0);
        chk("run.count_first_idle", count0, 0);
        tick();
        chk("run.count_reloaded", count0, 7);

        // pause for 6 cycles mid-run
        start0 = 1'b1; tick(); start0 = 1'b0;
        tl = cyc;
        repeat (10) tick();
        pause0 = 1'b1;
        ca = -1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k == 0) ca = count0;
            chk("pause.ena", cnt_ena0, 0);
            chk("pause.paused", paused0, 1);
        end
        chk("pause.count_held_lit", ca, 5);
        chk("pause.count_frozen", count0, ca);
        pause0 = 1'b0;
        t = -1;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (done0) begin t = cyc; break; end
        end
        chk("pause.latency", t - tl, 36);
        tick();
        chk("pause.rounds", rounds0, 2);

        // abort with count = 3
        repeat (2) tick();
        start0 = 1'b1; tick(); start0 = 1'b0;
        t = -1;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (count0 == 8'd3) begin t = cyc; break; end
        end
        chk("abort3.found", t >= 0, 1);
        abort0 = 1'b1; tick(); abort0 = 1'b0;
        chk("abort3.busy", busy0, 0);
        chk("abort3.cnt_reset", cnt_reset0, 1);
        chk("abort3.done", done0, 0);
        tick();
        chk("abort3.count", count0, 7);
        chk("abort3.rounds", rounds0, 2);

        // abort in the same cycle count reaches zero
        start0 = 1'b1; tick(); start0 = 1'b0;
        t = -1;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (count0 == 8'd0) begin t = cyc; break; end
        end
        chk("abort0.found", t >= 0, 1);
        abort0 = 1'b1; tick(); abort0 = 1'b0;
        chk("abort0.done", done0, 0);
        chk("abort0.busy", busy0, 0);
        tick();
        chk("abort0.rounds", rounds0, 2);
        chk("abort0.done_late", done0, 0);

        // start held high: relaunch after each DONE -> IDLE
        tick();
        start0 = 1'b1;
        t1 = -1; t2 = -1;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (done0) begin t1 = cyc; break; end
        end
        for (int k = 0; k < 100; k++) begin
            tick();
            if (done0) begin t2 = cyc; break; end
        end
        start0 = 1'b0;
        chk("held.gap", t2 - t1, 32);
        tick();
        chk("held.rounds", rounds0, 4);

        // auto-reload instance: done every 5 cycles, then saturate
        t1 = -1; t2 = -1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done1) begin t1 = cyc; break; end
        end
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done1) begin t2 = cyc; break; end
        end
        chk("auto.period", t2 - t1, 5);
        for (int k = 0; k < 2000; k++) begin
            if (rounds1 == 8'd255) break;
            tick();
        end
        chk("auto.saturated", rounds1, 255);
        repeat (20) tick();
        chk("auto.stays_255", rounds1, 255);
        chk("auto.busy_running", busy1 | done1, 1);

        // reset mid-run clears everything
        start0 = 1'b1; tick(); start0 = 1'b0;
        repeat (5) tick();
        reset = 1'b1; tick(); reset = 1'b0;
        chk("rst.rounds0", rounds0, 0);
        chk("rst.rounds1", rounds1, 0);
        chk("rst.busy0", busy0, 0);
        chk("rst.cnt_reset0", cnt_reset0, 1);
        tick();
        chk("rst.busy1", busy1, 0);
        chk("rst.count0", count0, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
